// File: rtl/ram_rd_stream.sv
// rtl/ram_rd_stream.sv - burst read master: async RAM read port to a registered valid/ready stream
// Optional abort input enabled by RAM_RD_STREAM_ABORT_EN.
module ram_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
`ifdef RAM_RD_STREAM_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] remain;
  logic                  abort_hit;
  logic                  fetch;

`ifdef RAM_RD_STREAM_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // An abort suppresses the RAM access it would otherwise have overlapped.
  assign fetch       = (state == READ) && (!out_valid || out_ready) && !abort_hit;
  assign ram_cs      = fetch;
  assign ram_oe      = fetch;
  assign ram_we      = 1'b0;
  assign ram_address = rd_addr;
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              rd_addr <= cmd_addr;
              remain  <= cmd_len;
              state   <= READ;
            end
          end
          READ: begin
            if (fetch) begin
              out_data  <= ram_data;
              out_valid <= 1'b1;
              out_last  <= (remain == '0);
              rd_addr   <= rd_addr + ADDR_WIDTH'(1);
              remain    <= remain - ADDR_WIDTH'(1);
              if (remain == '0) state <= DRAIN;
            end else if (out_valid && out_ready) begin
              out_valid <= 1'b0;
            end
          end
          DRAIN: begin
            // The final word is already registered; just wait for its handshake.
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
              done      <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb/tb_ram_rd_stream.sv - directed self-checking bench for ram_rd_stream
// Define RAM_RD_STREAM_ABORT_EN for both files to exercise the abort port.
module tb_ram_rd_stream;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] ram_address;
  logic       ram_cs;
  logic       ram_oe;
  logic       ram_we;
  logic [7:0] ram_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef RAM_RD_STREAM_ABORT_EN
  logic       abort;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  logic [7:0] a_words [0:3];

  always #5 clk = ~clk;

  assign ram_data = (ram_cs && ram_oe) ? mem[ram_address] : 8'h00;

  ram_rd_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_address(ram_address), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_data(ram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
`ifdef RAM_RD_STREAM_ABORT_EN
    .abort(abort),
`endif
    .done(done)
  );

  // Offers a command for one cycle; returns in the cycle after acceptance (E0..E1).
  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if ({ram_cs, ram_oe, ram_we} !== 3'b000) begin failures++; $display("FAIL reset_ram_ctl got=%b want=000", {ram_cs, ram_oe, ram_we}); end
    checks++; if (ram_address !== 8'h00) begin failures++; $display("FAIL reset_ram_address got=%h want=00", ram_address); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    issue_cmd(8'h10, 8'd3);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_e0_valid got=%b want=0", out_valid); end
    checks++; if (ram_cs !== 1'b1 || ram_address !== 8'h10) begin failures++; $display("FAIL basic_first_fetch got=cs%b/%h want=cs1/10", ram_cs, ram_address); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== a_words[k]) begin failures++; $display("FAIL basic_word%0d got=v%b/%h want=v1/%h", k, out_valid, out_data, a_words[k]); end
      checks++; if (out_last !== (k == 3)) begin failures++; $display("FAIL basic_last%0d got=%b want=%b", k, out_last, (k == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_done got=d%b v%b r%b want=d1 v0 r1", done, out_valid, cmd_ready); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    int got;
    logic       prev_stall;
    logic [7:0] prev_data;
    pat = 4'b1001;
    got = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    out_ready = 1'b1;
    issue_cmd(8'h10, 8'd3);
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      #1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin failures++; $display("FAIL bp_hold got=v%b/%h want=v1/%h", out_valid, out_data, prev_data); end
      end
      if (out_valid && !out_ready) begin
        checks++; if (ram_cs !== 1'b0 || ram_oe !== 1'b0) begin failures++; $display("FAIL bp_stall_cs got=%b%b want=00", ram_cs, ram_oe); end
      end
      if (out_valid && out_ready) begin
        checks++; if (out_data !== a_words[got] || out_last !== (got == 3)) begin failures++; $display("FAIL bp_word%0d got=%h/l%b want=%h/l%b", got, out_data, out_last, a_words[got], (got == 3)); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
    checks++; if (got != 4) begin failures++; $display("FAIL bp_count got=%0d want=4", got); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b want=1", done); end
    out_ready = 1'b1;
  endtask

  task automatic test_wrap;
    logic [7:0] ea;
    out_ready = 1'b1;
    issue_cmd(8'hFE, 8'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      ea = 8'hFE + 8'(k);
      checks++; if (out_valid !== 1'b1 || out_data !== mem[ea] || out_last !== (k == 3)) begin failures++; $display("FAIL wrap_word%0d got=v%b/%h/l%b want=v1/%h/l%b", k, out_valid, out_data, out_last, mem[ea], (k == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b want=1", done); end
  endtask

  task automatic test_full_depth;
    logic [7:0] ea;
    int bad;
    bad = 0;
    out_ready = 1'b1;
    issue_cmd(8'h80, 8'hFF);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 100) begin
        cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_len = 8'd0;
      end
      #1;
      ea = 8'h80 + 8'(k);
      if (out_valid !== 1'b1 || out_data !== mem[ea] || out_last !== (k == 255)) begin
        if (bad == 0) $display("FAIL full_word%0d got=v%b/%h/l%b want=v1/%h/l%b", k, out_valid, out_data, out_last, mem[ea], (k == 255));
        bad++;
      end
      if (k == 100) begin
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_cmd_held_off got=%b want=0", cmd_ready); end
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_words got=%0d_bad want=0_bad", bad); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL full_done got=d%b r%b want=d1 r1", done, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_pending_accept got=%b want=1", busy); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== a_words[0] || out_last !== 1'b1) begin failures++; $display("FAIL full_next_word got=v%b/%h/l%b want=v1/%h/l1", out_valid, out_data, out_last, a_words[0]); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_next_done got=%b want=1", done); end
  endtask

  task automatic test_reset_mid_burst;
    logic [7:0] ea;
    out_ready = 1'b1;
    issue_cmd(8'h20, 8'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      ea = 8'h20 + 8'(k);
      checks++; if (out_valid !== 1'b1 || out_data !== mem[ea]) begin failures++; $display("FAIL rst_word%0d got=v%b/%h want=v1/%h", k, out_valid, out_data, mem[ea]); end
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=v%b b%b d%b l%b want=v0 b0 d0 l0", out_valid, busy, done, out_last); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_idle got=d%b r%b want=d0 r1", done, cmd_ready); end
    issue_cmd(8'h12, 8'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== a_words[k + 2] || out_last !== (k == 1)) begin failures++; $display("FAIL rst_new_word%0d got=v%b/%h/l%b want=v1/%h/l%b", k, out_valid, out_data, out_last, a_words[k + 2], (k == 1)); end
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_new_done got=%b want=1", done); end
  endtask

`ifdef RAM_RD_STREAM_ABORT_EN
  task automatic test_abort;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=d%b b%b want=d0 b0", done, busy); end
    issue_cmd(8'h10, 8'd3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_burst got=v%b d%b r%b want=v0 d1 r1", out_valid, done, cmd_ready); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_after got=d%b v%b want=d0 v0", done, out_valid); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    a_words[0] = 8'hA0; a_words[1] = 8'hA1; a_words[2] = 8'hA2; a_words[3] = 8'hA3;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = a_words[i];
    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00; out_ready = 1'b0;
`ifdef RAM_RD_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_full_depth;
    test_reset_mid_burst;
`ifdef RAM_RD_STREAM_ABORT_EN
    test_abort;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rd_stream.md
# ram_rd_stream

Read-side streaming master for the dual-port asynchronous RAM. It accepts a (start address, length) command and drives the RAM's asynchronous read port (address, chip select, output enable, write enable held low). It returns the words in address order on a valid/ready stream through a single output register. It sits between the RAM and any consumer that needs buffered, back-pressured bursts instead of raw combinational reads.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width; must match the RAM instance
- ADDR_WIDTH, 8, RAM address width; RAM_DEPTH = 1 << ADDR_WIDTH

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rstn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  ADDR_WIDTH  word count minus one (0 → 1 word, all-ones → RAM_DEPTH words)
- ram_address  out  ADDR_WIDTH  RAM read-port address
- ram_cs  out  1  RAM read-port chip select
- ram_oe  out  1  RAM read-port output enable
- ram_we  out  1  RAM read-port write enable; constant 0
- ram_data  in  DATA_WIDTH  RAM read-port data (combinational, 0 when not enabled)
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_WIDTH  registered word
- out_last  out  1  qualifies final word of burst
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on burst completion

## Operation
- States:
  - IDLE → READ on cmd_valid && cmd_ready. The transition loads rd_addr = cmd_addr and remain = cmd_len.
  - READ → DRAIN when the last word (remain == 0) is captured.
  - DRAIN → IDLE when out_valid && out_ready. done = 1 for that single cycle, registered: it is high in the first IDLE cycle.
- Capture condition `fetch` = (state == READ) && (!out_valid || out_ready).
- ram_cs = ram_oe = fetch. ram_address = rd_addr at all times.
- On fetch:
  - out_data ← ram_data, out_valid ← 1, out_last ← (remain == 0).
  - rd_addr ← rd_addr + 1, modulo RAM_DEPTH: all-ones wraps to 0.
  - remain ← remain − 1.
- When out_valid && out_ready && !fetch: out_valid ← 0.
- out_data and out_last hold their values while out_valid && !out_ready.
- Commands are only accepted in IDLE. A cmd_valid seen in READ or DRAIN is ignored and held off by cmd_ready = 0.
- Reads see RAM contents combinationally in the fetch cycle. A same-cycle write to rd_addr on port 0 is returned if the write is already visible; ordering with writers is the caller's responsibility.

## Timing
- Reset (rstn = 0 at an edge), regardless of state:
  - state = IDLE, out_valid = 0, out_last = 0, out_data = 0, done = 0, busy = 0, cmd_ready = 1 afterward.
  - ram_cs = ram_oe = ram_we = 0; rd_addr = 0, remain = 0.
- Reset mid-burst drops the burst silently: no done pulse and no partial out_last.
- Latency: command accepted at edge E0 → fetch during the E0–E1 cycle → out_valid at E1.
- Throughput: one word per cycle while out_ready = 1. An N-word burst with out_ready held high gives out_valid from E1 through EN. done is seen one cycle after the last word is accepted.
- Back-pressure: with out_ready = 0, no fetch happens, ram_cs/ram_oe = 0 and rd_addr is stable.
- Minimum command-to-command spacing: a new cmd is accepted in the done cycle, i.e. one idle cycle between bursts.

## Configuration
- RAM_RD_STREAM_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - abort = 1 in READ or DRAIN forces state → IDLE and out_valid → 0 at the next edge, and pulses done.
  - abort in IDLE has no effect.
  - abort takes priority over fetch in the same cycle.
- Not defined: port absent; a burst always runs to completion.

## Test plan
- Preload mem[0x10..0x13] = A0..A3. cmd_addr = 0x10, cmd_len = 3, out_ready = 1 → out_data A0,A1,A2,A3 on four consecutive cycles starting at E1; out_last only on A3; done one cycle later.
- Same burst with out_ready toggled 1,0,0,1,… → no word lost or duplicated; out_data stable while stalled; ram_cs = 0 during stalls.
- Wrap: cmd_addr = 0xFE, cmd_len = 3 → words from addresses 0xFE, 0xFF, 0x00, 0x01.
- Full depth: cmd_len = 0xFF → 256 words, out_last on the 256th; cmd_valid asserted mid-burst is ignored until the done cycle.
- Reset at the third word of an 8-word burst → next cycle out_valid = 0, busy = 0, no done; a new command is then accepted normally.
- With RAM_RD_STREAM_ABORT_EN, abort on the second fetch of a 4-word burst → out_valid = 0 next edge, done pulses, cmd_ready = 1.
